pipeline_issue_queue: RTL and testbench

Issue stage that sits directly upstream of the first pipeline_stage in the global-stall address pipeline. It accepts address requests from a producer over a valid/ready handshake and buffers them in a small FIFO. Each request receives a sequential ID, and the block drives the address/id/valid triple into the pipeline under the global stall. It enforces an outstanding-transaction credit limit, replenished by retire pulses from the pipeline tail.

---
 rtl/pipeline_issue_queue.sv | 105 ++++++++++
 tb/tb_pipeline_issue_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_issue_queue.sv
// Issue stage ahead of the global-stall address pipeline: buffers producer
// requests in a FIFO, tags them with sequential IDs and meters them by credit.
module pipeline_issue_queue #(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int ID_WIDTH        = 4,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_address,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [ID_WIDTH-1:0]      out_id,
  output logic                     out_valid,
  input  logic                     in_stall,
  input  logic                     retire_valid,
  output logic [CNT_W-1:0]         fifo_count,
  output logic [OUT_W-1:0]         outstanding,
  output logic                     retire_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready depends only on registered occupancy, never on req_valid or a pop.
  logic [ADDRESS_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [OUT_W-1:0]         outst_q, outst_d;
  logic [ID_WIDTH-1:0]      next_id_q, next_id_d;
  logic [ADDRESS_WIDTH-1:0] out_address_q, out_address_d;
  logic [ID_WIDTH-1:0]      out_id_q, out_id_d;
  logic                     out_valid_q, out_valid_d;
  logic                     retire_err_q, retire_err_d;
  logic                     push, pop, retire_ok;

  assign req_ready = !reset && (count_q != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  // Credit check uses the pre-edge count, so a same-edge retire frees nothing yet.
  assign pop       = !in_stall && (count_q != '0) && (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign retire_ok = retire_valid && (outst_q != '0);

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    next_id_d     = next_id_q;
    out_address_d = out_address_q;
    out_id_d      = out_id_q;
    out_valid_d   = out_valid_q;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    outst_d       = outst_q + OUT_W'(pop) - OUT_W'(retire_ok);
    retire_err_d  = retire_err_q || (retire_valid && (outst_q == '0));
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (!in_stall) begin
      out_valid_d = pop;
      if (pop) begin
        out_address_d = mem_q[rd_ptr_q];
        out_id_d      = next_id_q;
        next_id_d     = next_id_q + ID_WIDTH'(1);
        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= req_address;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outst_q       <= '0;
      next_id_q     <= '0;
      out_address_q <= '0;
      out_id_q      <= '0;
      out_valid_q   <= 1'b0;
      retire_err_q  <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outst_q       <= outst_d;
      next_id_q     <= next_id_d;
      out_address_q <= out_address_d;
      out_id_q      <= out_id_d;
      out_valid_q   <= out_valid_d;
      retire_err_q  <= retire_err_d;
    end
  end

  assign out_address = out_address_q;
  assign out_id      = out_id_q;
  assign out_valid   = out_valid_q;
  assign fifo_count  = count_q;
  assign outstanding = outst_q;
  assign retire_err  = retire_err_q;

endmodule

// File: tb/tb_pipeline_issue_queue.sv
// Directed bench for pipeline_issue_queue: issue, stall, credits, ID wrap,
// retire errors and mid-operation reset against hand-computed values.
module tb_pipeline_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_address;
  logic [15:0] out_address;
  logic [3:0]  out_id;
  logic        out_valid;
  logic        in_stall;
  logic        retire_valid;
  logic [2:0]  fifo_count;
  logic [3:0]  outstanding;
  logic        retire_err;

  int checks   = 0;
  int failures = 0;

  pipeline_issue_queue dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_address  (req_address),
    .out_address  (out_address),
    .out_id       (out_id),
    .out_valid    (out_valid),
    .in_stall     (in_stall),
    .retire_valid (retire_valid),
    .fifo_count   (fifo_count),
    .outstanding  (outstanding),
    .retire_err   (retire_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] a, input logic [3:0] id);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_addr"}, 32'(out_address), 32'(a));
    check({tag, "_id"}, 32'(out_id), 32'(id));
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; in_stall = 1'b0; retire_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_address = '0; in_stall = 1'b0; retire_valid = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(req_ready), 0);
    check_out("rst", 1'b0, 16'h0, 4'h0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_outst", 32'(outstanding), 0);
    check("rst_err", 32'(retire_err), 0);
    reset = 1'b0; #1;
    check("rel_ready", 32'(req_ready), 1);

    // Basic issue: one-cycle latency, back-to-back issue
    req_valid = 1'b1; req_address = 16'h0010; tick();
    check("b0_valid", 32'(out_valid), 0);
    check("b0_count", 32'(fifo_count), 1);
    req_address = 16'h0020; tick();
    check_out("b1", 1'b1, 16'h0010, 4'd0);
    req_address = 16'h0030; tick();
    check_out("b2", 1'b1, 16'h0020, 4'd1);
    req_valid = 1'b0; tick();
    check_out("b3", 1'b1, 16'h0030, 4'd2);
    check("b3_count", 32'(fifo_count), 0);
    check("b3_outst", 32'(outstanding), 3);
    tick();
    check_out("b4", 1'b0, 16'h0030, 4'd2);

    // Stall hold
    do_reset();
    in_stall = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_address = 16'h0100 * 16'(i + 1); tick();
    end
    check("s_fill_count", 32'(fifo_count), 4);
    check("s_fill_ready", 32'(req_ready), 0);
    check("s_fill_valid", 32'(out_valid), 0);
    in_stall = 1'b0; req_valid = 1'b0; tick();
    check_out("s_i0", 1'b1, 16'h0100, 4'd0);
    tick();
    check_out("s_i1", 1'b1, 16'h0200, 4'd1);
    check("s_i1_count", 32'(fifo_count), 2);
    in_stall = 1'b1; req_valid = 1'b1; req_address = 16'h0500; tick();
    check_out("s_h0", 1'b1, 16'h0200, 4'd1);
    check("s_h0_count", 32'(fifo_count), 3);
    req_address = 16'h0600; tick();
    check_out("s_h1", 1'b1, 16'h0200, 4'd1);
    check("s_h1_count", 32'(fifo_count), 4);
    check("s_h1_ready", 32'(req_ready), 0);
    req_address = 16'h0700; tick();
    check_out("s_h2", 1'b1, 16'h0200, 4'd1);
    tick();
    check_out("s_h3", 1'b1, 16'h0200, 4'd1);
    check("s_h3_count", 32'(fifo_count), 4);
    in_stall = 1'b0; req_valid = 1'b0; tick();
    check_out("s_r0", 1'b1, 16'h0300, 4'd2);
    check("s_r0_count", 32'(fifo_count), 3);
    tick(); tick(); tick();
    check_out("s_r3", 1'b1, 16'h0600, 4'd5);
    check("s_r3_outst", 32'(outstanding), 6);

    // Credit limit
    do_reset();
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_address = 16'h1000 + 16'(i); tick();
      if (i >= 1 && i <= 8) check_out("c_iss", 1'b1, 16'h1000 + 16'(i - 1), 4'(i - 1));
    end
    check("c_lim_valid", 32'(out_valid), 0);
    check("c_lim_outst", 32'(outstanding), 8);
    check("c_lim_count", 32'(fifo_count), 2);
    req_valid = 1'b0; tick();
    check("c_hold_valid", 32'(out_valid), 0);
    retire_valid = 1'b1; tick();
    check("c_ret_valid", 32'(out_valid), 0);
    check("c_ret_outst", 32'(outstanding), 7);
    retire_valid = 1'b0; tick();
    check_out("c_9th", 1'b1, 16'h1008, 4'd8);
    check("c_9th_outst", 32'(outstanding), 8);

    // ID wrap with prompt retire; issue+retire on one edge keeps outstanding
    do_reset();
    for (int i = 0; i < 18; i++) begin
      req_valid = 1'b1; req_address = 16'h2000 + 16'(i);
      retire_valid = (i >= 2); tick();
      if (i >= 1) begin
        check_out("w_iss", 1'b1, 16'h2000 + 16'(i - 1), 4'((i - 1) % 16));
        check("w_outst", 32'(outstanding), 1);
      end
    end
    req_valid = 1'b0; retire_valid = 1'b1; tick();
    check_out("w_last", 1'b1, 16'h2011, 4'd1);
    check("w_last_outst", 32'(outstanding), 1);
    check("w_err0", 32'(retire_err), 0);
    tick();
    check("w_drain_outst", 32'(outstanding), 0);
    check("w_drain_err", 32'(retire_err), 0);
    tick();
    check("e_under_outst", 32'(outstanding), 0);
    check("e_under_err", 32'(retire_err), 1);
    retire_valid = 1'b0; tick(); tick();
    check("e_sticky_err", 32'(retire_err), 1);

    // Reset mid-operation
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_address = 16'h3000 + 16'(i); tick();
    end
    req_valid = 1'b0; tick();
    in_stall = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_address = 16'h3100 + 16'(i); tick();
    end
    check("m_pre_count", 32'(fifo_count), 3);
    check("m_pre_outst", 32'(outstanding), 5);
    reset = 1'b1; req_valid = 1'b0; in_stall = 1'b0; #1;
    check("m_rst_ready", 32'(req_ready), 0);
    tick();
    check_out("m_rst", 1'b0, 16'h0, 4'h0);
    check("m_rst_count", 32'(fifo_count), 0);
    check("m_rst_outst", 32'(outstanding), 0);
    check("m_rst_err", 32'(retire_err), 0);
    reset = 1'b0; #1;
    check("m_rel_ready", 32'(req_ready), 1);
    retire_valid = 1'b1; tick();
    check("m_ret_err", 32'(retire_err), 1);
    check("m_ret_outst", 32'(outstanding), 0);
    retire_valid = 1'b0; req_valid = 1'b1; req_address = 16'h4000; tick();
    req_valid = 1'b0; tick();
    check_out("m_first", 1'b1, 16'h4000, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
